sa_req_issuer_2x2: RTL and testbench
====================================

// Module: sa_req_issuer_2x2
// PURPOSE
//  Requester side of the 2x2 root switch allocator. Buffers flits arriving on two input ports.
//  Drives a one-bit req per port while that port's FIFO is non-empty.
//  Consumes the allocator's same-cycle ack: pops the acked head and registers it onto the
//  switch-traversal output. Also checks ack legality and reports violations.
// PARAMETERS
//  DATA_W  32  flit payload width in bits
//  DEPTH   4   entries per input FIFO; power of two, >= 2
// PORTS
//  clk        in   1         single clock; all state on posedge
//  rst_n      in   1         asynchronous, active-low reset
//  in_valid   in   2         per-port flit valid
//  in_data    in   2*DATA_W  port i payload at [i*DATA_W +: DATA_W]
//  in_ready   out  2         per-port FIFO not full
//  req        out  2         to allocator: req[i] = FIFO i non-empty
//  ack        in   2         from allocator, combinational in the same cycle as req
//  out_valid  out  1         registered: a flit won allocation last cycle
//  out_data   out  DATA_W    registered winning payload
//  out_src    out  1         registered index of the winning port
//  err_ack    out  1         sticky protocol-violation flag
// BEHAVIOUR
//  Reset (async assert, sync deassert use):
//   - FIFOs empty, pointers and counts 0.
//   - req=00, in_ready=11, out_valid=0, out_data=0, out_src=0, err_ack=0.
//  FIFO i:
//   - Occupancy counter is $clog2(DEPTH+1) bits; rd/wr pointers are $clog2(DEPTH) bits and wrap naturally.
//   - in_ready[i] = (count_i != DEPTH); this is a function of registered state only.
//   - push_i = in_valid[i] & in_ready[i]. A full FIFO refuses a push even when it pops in the same cycle.
//  Request: req[i] = (count_i != 0). This is registered-state only; there is no combinational path from ack to req.
//  Legal ack: ack is 00, 01, or 10, and ack[i] implies req[i].
//   - pop_i = legal & ack[i] & req[i]. At most one pop per cycle.
//  Illegal ack:
//   - ack==11, or ack[i] asserted while req[i]==0.
//   - No pop on either port. err_ack <= 1, held until reset.
//  Output stage, 1-cycle latency ack -> out_valid:
//   - out_valid <= |pop.
//   - On a pop: out_data <= head of the popped FIFO, out_src <= i.
//   - With no pop, out_data and out_src hold their last values.
//   - No backpressure on the output.
//  Simultaneous push and pop on the same FIFO:
//   - Count is unchanged and both pointers advance.
//   - A push into an empty FIFO is not visible on req until the next cycle, so there is no bypass.
//  Ordering: strict FIFO within each port. Cross-port order is decided only by ack.
//  Reset mid-operation: all buffered flits are discarded; outputs return to their reset values immediately.
// STRUCTURE
//  Package sa_pkg:
//   - SA_PORTS=2 and a port index typedef.
//   - Function ack_legal(req, ack), shared with the allocator's assertions.
//  Sub-module sa_req_fifo:
//   - Params DATA_W, DEPTH. Ports: push, push_data, pop, head, full, empty.
//   - Instantiated twice, one per port.
//  Top level: ack check, pop decode, output register, err_ack flop.
// TESTING
//  1. Reset -> req=00, in_ready=11, out_valid=0, err_ack=0.
//  2. Push 0xA5 on port 0 -> req=01 next cycle; ack=01 -> following cycle out_valid=1,
//     out_data=0xA5, out_src=0, req=00.
//  3. Push 4 flits (1..4) on port 1 -> in_ready[1]=0 after the 4th push; a 5th push (value 5) is dropped;
//     ack=10 for 4 cycles -> outputs 1,2,3,4 in order, then req=00.
//  4. Both ports hold 2 flits, ack alternates 01/10 -> interleaved output with correct out_src.
//     Concurrent push+pop on a full port 0 -> push refused, count=DEPTH-1.
//  5. ack=11 with req=11 -> no pop, err_ack=1 and stays 1.
//     After a reset, ack=10 with req=01 -> no pop, err_ack=1.
//  6. Load 3 flits, assert rst_n=0 mid-drain -> req=00, out_valid=0 at once; after release the FIFOs are empty.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared definitions for the 2x2 switch allocator: port count, port index type
// and the ack legality rule used by both the requester and allocator checks.
package sa_pkg;

  localparam int SA_PORTS = 2;

  typedef logic [0:0] sa_port_t;

  // Legal: one-hot or zero ack, and every acked port must be requesting.
  function automatic logic ack_legal(input logic [SA_PORTS-1:0] req,
                                     input logic [SA_PORTS-1:0] ack);
    return (ack != 2'b11) && ((ack & ~req) == 2'b00);
  endfunction

endpackage

// File: rtl/sa_req_fifo.sv
// Per-port input FIFO with occupancy counter; full/empty come from registered state only.
module sa_req_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // A full FIFO refuses a push even if it is popped in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sa_req_issuer_2x2.sv
// Requester side of the 2x2 root switch allocator: buffers input flits, raises req,
// pops on a legal same-cycle ack and registers the winner onto the traversal output.
module sa_req_issuer_2x2
  import sa_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [SA_PORTS-1:0]        in_valid,
  input  logic [SA_PORTS*DATA_W-1:0] in_data,
  output logic [SA_PORTS-1:0]        in_ready,
  output logic [SA_PORTS-1:0]        req,
  input  logic [SA_PORTS-1:0]        ack,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output sa_port_t                   out_src,
  output logic                       err_ack
);

  logic [DATA_W-1:0]   head [SA_PORTS];
  logic [SA_PORTS-1:0] full;
  logic [SA_PORTS-1:0] empty;
  logic [SA_PORTS-1:0] push;
  logic [SA_PORTS-1:0] pop;
  logic                legal;

  for (genvar i = 0; i < SA_PORTS; i++) begin : g_port
    sa_req_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[i]),
      .push_data (in_data[i*DATA_W +: DATA_W]),
      .pop       (pop[i]),
      .head      (head[i]),
      .full      (full[i]),
      .empty     (empty[i])
    );
  end

  assign in_ready = ~full;
  assign req      = ~empty;
  assign push     = in_valid & in_ready;
  assign legal    = ack_legal(req, ack);
  // An illegal ack suppresses both pops so no flit is lost to a bad grant.
  assign pop      = legal ? (ack & req) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      err_ack   <= 1'b0;
    end else begin
      out_valid <= |pop;
      if (|pop) begin
        out_data <= pop[1] ? head[1] : head[0];
        out_src  <= sa_port_t'(pop[1]);
      end
      if (!legal) err_ack <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sa_req_issuer_2x2.sv
// Directed bench for sa_req_issuer_2x2: a per-port queue model predicts req/in_ready/err_ack,
// and a scoreboard of expected winners is checked against the registered output stage.
module tb_sa_req_issuer_2x2;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [1:0]          in_valid = '0;
  logic [2*DATA_W-1:0] in_data = '0;
  logic [1:0]          in_ready;
  logic [1:0]          req;
  logic [1:0]          ack = '0;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [0:0]          out_src;
  logic                err_ack;

  int checks = 0;
  int errors = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [32:0] sb[$];
  logic        m_err = 1'b0;

  always #5 clk = ~clk;

  sa_req_issuer_2x2 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .req       (req),
    .ack       (ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .err_ack   (err_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
  task automatic tick(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [1:0] a);
    logic [1:0]  m_req;
    logic [1:0]  m_rdy;
    logic        legal;
    logic        popped;
    logic [32:0] e;
    m_req = {q1.size() != 0, q0.size() != 0};
    m_rdy = {q1.size() != DEPTH, q0.size() != DEPTH};
    chk("req", 32'(req), 32'(m_req));
    chk("in_ready", 32'(in_ready), 32'(m_rdy));
    in_valid = v;
    in_data  = {d1, d0};
    ack      = a;
    legal  = (a != 2'b11) && ((a & ~m_req) == 2'b00);
    popped = 1'b0;
    if (!legal) m_err = 1'b1;
    else if (a[0] && m_req[0]) begin sb.push_back({1'b0, q0.pop_front()}); popped = 1'b1; end
    else if (a[1] && m_req[1]) begin sb.push_back({1'b1, q1.pop_front()}); popped = 1'b1; end
    if (v[0] && m_rdy[0]) q0.push_back(d0);
    if (v[1] && m_rdy[1]) q1.push_back(d1);
    @(posedge clk);
    #1;
    in_valid = '0;
    ack      = '0;
    chk("out_valid", 32'(out_valid), 32'(popped));
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e[31:0]);
        chk("out_src", 32'(out_src), 32'(e[32]));
      end
    end
    chk("err_ack", 32'(err_ack), 32'(m_err));
  endtask

  task automatic reset_dut();
    rst_n    = 1'b0;
    in_valid = '0;
    ack      = '0;
    #1;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'h3);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    chk("rst_err_ack", 32'(err_ack), 32'd0);
    q0.delete();
    q1.delete();
    sb.delete();
    m_err = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // 1. reset
    @(posedge clk);
    #1;
    reset_dut();

    // 2. single flit on port 0
    tick(2'b01, 32'hA5, 32'h0, 2'b00);
    tick(2'b00, 32'h0, 32'h0, 2'b01);
    tick(2'b00, 32'h0, 32'h0, 2'b00);

    // 3. fill port 1, fifth push refused, drain in order
    for (int k = 1; k <= 5; k++) tick(2'b10, 32'h0, 32'(k), 2'b00);
    for (int k = 0; k < 4; k++) tick(2'b00, 32'h0, 32'h0, 2'b10);
    tick(2'b00, 32'h0, 32'h0, 2'b00);

    // 4. interleaved drain of both ports
    for (int k = 0; k < 2; k++) tick(2'b11, 32'h10 + 32'(k), 32'h20 + 32'(k), 2'b00);
    for (int k = 0; k < 4; k++) tick(2'b00, 32'h0, 32'h0, (k % 2 == 0) ? 2'b01 : 2'b10);
    tick(2'b00, 32'h0, 32'h0, 2'b00);
    // push+pop on a full port 0: push refused, three remain
    for (int k = 0; k < 4; k++) tick(2'b01, 32'h30 + 32'(k), 32'h0, 2'b00);
    tick(2'b01, 32'h99, 32'h0, 2'b01);
    for (int k = 0; k < 3; k++) tick(2'b00, 32'h0, 32'h0, 2'b01);
    tick(2'b00, 32'h0, 32'h0, 2'b00);

    // 5. illegal acks
    tick(2'b11, 32'h41, 32'h51, 2'b00);
    tick(2'b00, 32'h0, 32'h0, 2'b11);
    tick(2'b00, 32'h0, 32'h0, 2'b00);
    tick(2'b00, 32'h0, 32'h0, 2'b00);
    reset_dut();
    tick(2'b01, 32'h77, 32'h0, 2'b00);
    tick(2'b00, 32'h0, 32'h0, 2'b10);
    tick(2'b00, 32'h0, 32'h0, 2'b00);

    // 6. reset mid-drain
    reset_dut();
    for (int k = 0; k < 3; k++) tick(2'b01, 32'h60 + 32'(k), 32'h0, 2'b00);
    tick(2'b00, 32'h0, 32'h0, 2'b01);
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    reset_dut();
    tick(2'b00, 32'h0, 32'h0, 2'b00);
    tick(2'b00, 32'h0, 32'h0, 2'b00);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
